// File: rtl/signed_divider_8bit.sv
// Sequential two's-complement divider: restoring shift-subtract on magnitudes,
// one quotient bit per SHIFT/SUB pair, followed by a sign-fixup step.
module signed_divider_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             ClearA_LoadB,
  input  logic             Run,
  input  logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] Qval,
  output logic [WIDTH-1:0] Rval,
  output logic [WIDTH-1:0] Dval,
  output logic             Busy,
  output logic             Done,
  output logic             Div0,
  output logic             Ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES     = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0]    LAST_IT  = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    SUB   = 3'd3,
    FIXUP = 3'd4,
    DONE  = 3'd5
  } state_t;

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic en);
    neg_if = en ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d, dm_q, dm_d, n_q, n_d;
  logic [WIDTH-1:0] qval_q, qval_d, rval_q, rval_d, dval_q, dval_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sn_q, sn_d, sd_q, sd_d;
  logic             div0_q, div0_d, ovf_q, ovf_d, busy_q, busy_d, done_q, done_d;
  logic [WIDTH:0]   diff_s;
  logic             qsign_s;

  assign diff_s  = a_q - {1'b0, dm_q};
  assign qsign_s = sn_q ^ sd_q;

  // Next-state, datapath and result-register logic.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    dm_d    = dm_q;
    n_d     = n_q;
    qval_d  = qval_q;
    rval_d  = rval_q;
    dval_d  = dval_q;
    cnt_d   = cnt_q;
    sn_d    = sn_q;
    sd_d    = sd_q;
    div0_d  = div0_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (ClearA_LoadB) begin
          dval_d = S;
          qval_d = ZERO;
          rval_d = ZERO;
          div0_d = 1'b0;
          ovf_d  = 1'b0;
        end else if (Run) begin
          n_d     = S;
          div0_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (dval_q == ZERO) begin
          div0_d  = 1'b1;
          qval_d  = ONES;
          rval_d  = n_q;
          state_d = DONE;
        end else begin
          sn_d    = n_q[WIDTH-1];
          sd_d    = dval_q[WIDTH-1];
          q_d     = neg_if(n_q, n_q[WIDTH-1]);
          dm_d    = neg_if(dval_q, dval_q[WIDTH-1]);
          a_d     = {(WIDTH+1){1'b0}};
          cnt_d   = {CW{1'b0}};
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_d     = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
        q_d     = {q_q[WIDTH-2:0], 1'b0};
        state_d = SUB;
      end
      SUB: begin
        if (!diff_s[WIDTH]) begin
          a_d     = diff_s;
          q_d[0]  = 1'b1;
        end else begin
          a_d     = a_q;
        end
        if (cnt_q == LAST_IT) begin
          state_d = FIXUP;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = SHIFT;
        end
      end
      FIXUP: begin
        // Only -2^(W-1) / -1 yields a positive magnitude of 2^(W-1).
        if (q_q == MSB_ONLY && !qsign_s) begin
          ovf_d  = 1'b1;
          qval_d = MSB_ONLY;
          rval_d = ZERO;
        end else begin
          qval_d = neg_if(q_q, qsign_s);
          rval_d = neg_if(a_q[WIDTH-1:0], sn_q);
        end
        state_d = DONE;
      end
      DONE: begin
        if (Run) begin
          state_d = DONE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_d = (state_d == LOAD) || (state_d == SHIFT) || (state_d == SUB) || (state_d == FIXUP);
  assign done_d = (state_d == DONE);

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= IDLE;
      a_q     <= {(WIDTH+1){1'b0}};
      q_q     <= ZERO;
      dm_q    <= ZERO;
      n_q     <= ZERO;
      qval_q  <= ZERO;
      rval_q  <= ZERO;
      dval_q  <= ZERO;
      cnt_q   <= {CW{1'b0}};
      sn_q    <= 1'b0;
      sd_q    <= 1'b0;
      div0_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      dm_q    <= dm_d;
      n_q     <= n_d;
      qval_q  <= qval_d;
      rval_q  <= rval_d;
      dval_q  <= dval_d;
      cnt_q   <= cnt_d;
      sn_q    <= sn_d;
      sd_q    <= sd_d;
      div0_q  <= div0_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Qval = qval_q;
  assign Rval = rval_q;
  assign Dval = dval_q;
  assign Busy = busy_q;
  assign Done = done_q;
  assign Div0 = div0_q;
  assign Ovf  = ovf_q;

endmodule

// File: tb/tb_signed_divider_8bit.sv
// Directed self-checking bench for signed_divider_8bit with hand-computed results.
module tb_signed_divider_8bit;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       ClearA_LoadB = 1'b0;
  logic       Run = 1'b0;
  logic [7:0] S = 8'h00;
  logic [7:0] Qval, Rval, Dval;
  logic       Busy, Done, Div0, Ovf;

  int pass_cnt = 0;
  int total_cnt = 0;

  signed_divider_8bit #(.WIDTH(8)) dut (
    .Clk(Clk), .Reset(Reset), .ClearA_LoadB(ClearA_LoadB), .Run(Run), .S(S),
    .Qval(Qval), .Rval(Rval), .Dval(Dval), .Busy(Busy), .Done(Done),
    .Div0(Div0), .Ovf(Ovf)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Loads divisor d, starts dividend n with Run held; optional ClearA pulse mid-run.
  task automatic run_div(input logic [7:0] d, input logic [7:0] n, input int clr_at,
                         output int edges, output int busy_cycles);
    Run = 1'b0; ClearA_LoadB = 1'b0;
    tick();
    ClearA_LoadB = 1'b1; S = d;
    tick();
    ClearA_LoadB = 1'b0; S = n; Run = 1'b1;
    tick();
    S = 8'hA5;
    edges = 0;
    busy_cycles = 0;
    while (!Done && edges < 40) begin
      if (Busy) busy_cycles++;
      ClearA_LoadB = (edges == clr_at);
      S = (edges == clr_at) ? 8'h33 : 8'hA5;
      tick();
      edges++;
    end
    ClearA_LoadB = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    tick(); tick();
    total_cnt++;
    if ({Qval, Rval, Dval, Busy, Done, Div0, Ovf} !== 28'h0) begin
      $display("FAIL reset_outputs got %h want 0", {Qval, Rval, Dval, Busy, Done, Div0, Ovf});
    end else pass_cnt++;
    Reset = 1'b1;
    tick();
    total_cnt++;
    if ({Busy, Done} !== 2'b00) $display("FAIL reset_idle got %b want 00", {Busy, Done});
    else pass_cnt++;
  endtask

  task automatic test_basic();
    int e, b;
    run_div(8'd7, 8'd100, -1, e, b);
    total_cnt++;
    if (e !== 18) $display("FAIL basic_latency got %0d want 18", e); else pass_cnt++;
    total_cnt++;
    if (b !== 18) $display("FAIL basic_busy_cycles got %0d want 18", b); else pass_cnt++;
    total_cnt++;
    if ({Qval, Rval, Div0, Ovf, Busy} !== {8'h0E, 8'h02, 3'b000})
      $display("FAIL basic_result got q=%h r=%h d0=%b ov=%b bz=%b want q=0e r=02 flags 0", Qval, Rval, Div0, Ovf, Busy);
    else pass_cnt++;
  endtask

  task automatic test_signs();
    int e, b;
    logic [7:0] dv [3] = '{8'h07, 8'hF9, 8'hF9};
    logic [7:0] nv [3] = '{8'h9C, 8'h64, 8'h9C};
    logic [7:0] qe [3] = '{8'hF2, 8'hF2, 8'h0E};
    logic [7:0] re [3] = '{8'hFE, 8'h02, 8'hFE};
    for (int i = 0; i < 3; i++) begin
      run_div(dv[i], nv[i], -1, e, b);
      total_cnt++;
      if ({Qval, Rval} !== {qe[i], re[i]})
        $display("FAIL signs_%0d got q=%h r=%h want q=%h r=%h", i, Qval, Rval, qe[i], re[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_div0();
    int e, b;
    run_div(8'h00, 8'h55, -1, e, b);
    total_cnt++;
    if (e !== 1) $display("FAIL div0_latency got %0d want 1", e); else pass_cnt++;
    total_cnt++;
    if ({Div0, Ovf, Qval, Rval} !== {2'b10, 8'hFF, 8'h55})
      $display("FAIL div0_result got d0=%b ov=%b q=%h r=%h want d0=1 ov=0 q=ff r=55", Div0, Ovf, Qval, Rval);
    else pass_cnt++;
    run_div(8'd7, 8'd100, -1, e, b);
    total_cnt++;
    if ({Div0, Qval} !== {1'b0, 8'h0E}) $display("FAIL div0_cleared got d0=%b q=%h want d0=0 q=0e", Div0, Qval);
    else pass_cnt++;
  endtask

  task automatic test_ovf();
    int e, b;
    run_div(8'hFF, 8'h80, -1, e, b);
    total_cnt++;
    if ({Ovf, Qval, Rval} !== {1'b1, 8'h80, 8'h00})
      $display("FAIL ovf_set got ov=%b q=%h r=%h want ov=1 q=80 r=00", Ovf, Qval, Rval);
    else pass_cnt++;
    run_div(8'h01, 8'h80, -1, e, b);
    total_cnt++;
    if ({Ovf, Qval, Rval} !== {1'b0, 8'h80, 8'h00})
      $display("FAIL ovf_div1 got ov=%b q=%h r=%h want ov=0 q=80 r=00", Ovf, Qval, Rval);
    else pass_cnt++;
    run_div(8'h80, 8'h80, -1, e, b);
    total_cnt++;
    if ({Ovf, Qval, Rval} !== {1'b0, 8'h01, 8'h00})
      $display("FAIL min_by_min got ov=%b q=%h r=%h want ov=0 q=01 r=00", Ovf, Qval, Rval);
    else pass_cnt++;
  endtask

  task automatic test_hold_run();
    int e, b, bad;
    run_div(8'd7, 8'd100, -1, e, b);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (!Done || Busy || Qval !== 8'h0E) bad++;
    end
    total_cnt++;
    if (bad !== 0) $display("FAIL hold_done got %0d bad cycles want 0", bad); else pass_cnt++;
    Run = 1'b0;
    tick();
    total_cnt++;
    if ({Done, Busy} !== 2'b00) $display("FAIL drop_run got done/busy=%b want 00", {Done, Busy}); else pass_cnt++;
    Run = 1'b1; S = 8'd50;
    tick();
    total_cnt++;
    if (Busy !== 1'b1) $display("FAIL restart got busy=%b want 1", Busy); else pass_cnt++;
    for (int i = 0; i < 30 && !Done; i++) tick();
    total_cnt++;
    if ({Done, Qval, Rval} !== {1'b1, 8'h07, 8'h01})
      $display("FAIL restart_result got done=%b q=%h r=%h want done=1 q=07 r=01", Done, Qval, Rval);
    else pass_cnt++;
  endtask

  task automatic test_clear_while_busy();
    int e, b;
    run_div(8'd7, 8'd100, 5, e, b);
    total_cnt++;
    if ({Dval, Qval, Rval} !== {8'h07, 8'h0E, 8'h02})
      $display("FAIL clear_busy got dv=%h q=%h r=%h want dv=07 q=0e r=02", Dval, Qval, Rval);
    else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    Run = 1'b0;
    tick();
    ClearA_LoadB = 1'b1; S = 8'd7;
    tick();
    ClearA_LoadB = 1'b0; S = 8'd100; Run = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) tick();
    Reset = 1'b0;
    tick();
    total_cnt++;
    if ({Qval, Rval, Dval, Busy, Done, Div0, Ovf} !== 28'h0)
      $display("FAIL mid_reset got %h want 0", {Qval, Rval, Dval, Busy, Done, Div0, Ovf});
    else pass_cnt++;
    Reset = 1'b1; Run = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    total_cnt++;
    if ({Done, Busy} !== 2'b00) $display("FAIL post_reset_idle got %b want 00", {Done, Busy}); else pass_cnt++;
  endtask

  task automatic test_load_priority();
    ClearA_LoadB = 1'b1; Run = 1'b1; S = 8'd3;
    tick();
    total_cnt++;
    if ({Dval, Busy} !== {8'h03, 1'b0}) $display("FAIL load_priority got dv=%h bz=%b want dv=03 bz=0", Dval, Busy);
    else pass_cnt++;
    ClearA_LoadB = 1'b0; S = 8'd9;
    tick();
    total_cnt++;
    if (Busy !== 1'b1) $display("FAIL start_after_load got busy=%b want 1", Busy); else pass_cnt++;
    for (int i = 0; i < 30 && !Done; i++) tick();
    total_cnt++;
    if ({Done, Qval, Rval} !== {1'b1, 8'h03, 8'h00})
      $display("FAIL load_priority_result got done=%b q=%h r=%h want done=1 q=03 r=00", Done, Qval, Rval);
    else pass_cnt++;
    Run = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_div0();
    test_ovf();
    test_hold_run();
    test_clear_while_busy();
    test_mid_reset();
    test_load_priority();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
